// File: rtl/inv_key_sched_pkg.sv
// Shared AES constants and helpers: forward S-box, round constants,
// word type and the scheduler state encoding.
package inv_key_sched_pkg;

   localparam int KEY_W = 128;
   localparam int NR    = 10;

   typedef logic [31:0] word_t;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Forward AES S-box, shared with the forward key expansion.
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Round constant for rounds 1..10; other indices never occur.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/inv_key_round.sv
// Combinational inverse key-expansion step: round-r key in, round-(r-1) key out.
module inv_key_round
   import inv_key_sched_pkg::*;
(
   input  logic [KEY_W-1:0] key,
   input  logic [3:0]       rc,
   output logic [KEY_W-1:0] keyout
);

   word_t w0, w1, w2, w3;
   word_t n0, n1, n2, n3;
   word_t rot_word;
   word_t sub_word;

   assign w0 = key[127:96];
   assign w1 = key[95:64];
   assign w2 = key[63:32];
   assign w3 = key[31:0];

   // Words 1..3 of the previous key fall out of neighbouring XORs.
   assign n3 = w3 ^ w2;
   assign n2 = w2 ^ w1;
   assign n1 = w1 ^ w0;

   // RotWord on the recovered previous word 3, then four parallel S-box lookups.
   assign rot_word = {n3[23:0], n3[31:24]};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
         assign sub_word[8*gi +: 8] = sbox(rot_word[8*gi +: 8]);
      end
   endgenerate

   assign n0 = w0 ^ sub_word ^ {rcon(rc), 24'h000000};

   assign keyout = {n0, n1, n2, n3};

endmodule

// File: rtl/inv_key_sched.sv
// Iterative AES-128 inverse key scheduler: loads the round-10 key and
// streams rounds 10..0 over valid/ready, holding a single key register.
module inv_key_sched
   import inv_key_sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [KEY_W-1:0] key_in,
   output logic [KEY_W-1:0] key_out,
   output logic [3:0]       round_out,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             key_last,
   output logic             busy,
   output logic             done
);

   state_t           state_reg, state_next;
   logic [KEY_W-1:0] key_reg, key_next;
   logic [3:0]       round_reg, round_next;
   logic             done_reg, done_next;
   logic [KEY_W-1:0] step_key;

   inv_key_round u_round (
      .key    (key_reg),
      .rc     (round_reg),
      .keyout (step_key)
   );

   // State, key and round registers; reset aborts any sequence in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         key_reg   <= '0;
         round_reg <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         key_reg   <= key_next;
         round_reg <= round_next;
         done_reg  <= done_next;
      end
   end

   // Next-state: load on start in IDLE, step back one round per accepted key.
   always_comb begin
      state_next = state_reg;
      key_next   = key_reg;
      round_next = round_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               key_next   = key_in;
               round_next = 4'(NR);
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (key_ready) begin
               if (round_reg != 4'd0) begin
                  key_next   = step_key;
                  round_next = round_reg - 4'd1;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign key_out   = key_reg;
   assign round_out = round_reg;
   assign key_valid = (state_reg == EMIT);
   assign key_last  = key_valid && (round_reg == 4'd0);
   assign busy      = (state_reg == EMIT);
   assign done      = done_reg;

endmodule

// File: doc/inv_key_sched.md
Name: inv_key_sched

Overview:
- Iterative AES-128 inverse key scheduler for the decryptor. It sits directly downstream of Make_Inv_Key.
- It takes the final (round-10) round key produced there and emits the 11 round keys in decryption order: round 10, 9, … 0.
- It computes one round per cycle through a valid/ready stream into the inverse-round datapath.
- It replaces storing all 11 keys: only one 128-bit key register is held.

Parameters:
- NR, 10, number of rounds; only 10 is legal (Rcon table covers rounds 1..10).
- KEY_W, 128, key/round-key width; fixed at 128.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to load key_in; honoured only in IDLE.
- key_in  input  128  round-10 key (from Make_Inv_Key key_out); word 0 = bits [127:96].
- key_out  output  128  current round key.
- round_out  output  4  round index of key_out (10 down to 0).
- key_valid  output  1  key_out/round_out are valid.
- key_ready  input  1  consumer accepts key_out when key_valid && key_ready.
- key_last  output  1  high with key_valid when round_out == 0.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse after the round-0 key is accepted.

Behaviour:
- Reset (async, rst_n low): state = IDLE; key_out = 0, round_out = 0, key_valid = 0, key_last = 0, busy = 0, done = 0. Reset mid-sequence aborts immediately; no further keys are emitted.
- FSM states IDLE and EMIT.
- IDLE:
  - done is asserted only in the first IDLE cycle after the final handshake.
  - start = 1: on that edge, key_reg <= key_in and round <= NR, then go to EMIT.
  - key_valid rises the next cycle, giving a latency of 1 clk from start to the first key.
- EMIT, key_valid = 1:
  - Handshake with round > 0: key_reg <= inv_step(key_reg, round) and round <= round - 1; stay in EMIT.
  - Handshake with round == 0: go to IDLE, key_valid <= 0, done <= 1 for 1 cycle.
  - No handshake: key_out and round_out are held stable (standard valid/ready; valid never drops without acceptance).
- inv_step(K, r), with w0..w3 = K words [127:96]..[31:0]:
  - w3' = w3 ^ w2
  - w2' = w2 ^ w1
  - w1' = w1 ^ w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r], 24'h0}
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - RotWord rotates left by one byte; SubWord applies the forward S-box to each byte.
- Throughput with key_ready held high: 11 keys in 11 consecutive cycles; done on cycle 12 after the first valid.
- start while busy (EMIT) is ignored; the current sequence continues unchanged.
- start in the done cycle (IDLE) is accepted, so back-to-back sequences are allowed.
- key_last = key_valid && (round_out == 0).
- busy = (state == EMIT).
- The single combinational path (key_reg → 4 S-boxes → XOR → key_reg) must close timing at the decryptor clock.

Decomposition:
- Shared AES package holds:
  - the forward S-box function/table (shared with KeyGeneration);
  - the Rcon table indexed by round 1..10;
  - the KEY_W = 128 constant;
  - the NR = 10 constant;
  - a typedef for a 32-bit word.
- One sub-module: inv_key_round, a combinational inv_step with ports key, rc[3:0], keyout. It mirrors the existing KeyGeneration interface and instantiates four S-box lookups.
- The FSM, counter and register live in inv_key_sched.

Test Plan:
- FIPS-197 A.1 sequence, key_ready = 1, start with key_in = d014f9a8c9ee2589e13f0cc8b6630ca6 →
  - cycle+1: round 10 key equals key_in;
  - next: round 9 = ac7766f319fadc2128d12941575c006e;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c with key_last = 1;
  - done pulses on the following cycle.
- Backpressure: random key_ready (≈40% high) → same 11 keys in the same order; key_out/round_out stable whenever key_valid && !key_ready; exactly 11 handshakes, one done.
- start asserted with a different key_in at round 6 → ignored; remaining keys still match the A.1 sequence and busy stays 1.
- rst_n low at round 4, async mid-cycle → key_valid/busy drop immediately, all outputs 0; after release, a fresh start yields round 10 again.
- start asserted in the done cycle with key_in = round-10 key of an all-zero cipher key (b4ef5bcb3e92e21123e951cf6f8f188e) → accepted; final round-0 key = 000…0.
- start with key_ready = 0 → key_valid = 1 and round_out = 10 held indefinitely. Raising key_ready for one cycle advances to exactly round 9.
